// File: rtl/ring_flasher_sched.sv
// Step-enable generator and start-request arbiter for the ring LED flasher.
// Optional watchdog on RUN is built only when RING_FLASHER_SCHED_WATCHDOG_EN is defined.

module ring_flasher_sched #(
    parameter int PRESCALE    = 4,
    parameter int AUTO_PERIOD = 64,
    parameter int COOLDOWN    = 8,
    parameter int DONE_HOLD   = 3,
    parameter int TIMEOUT     = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        btn_req,
    input  logic        auto_en,
    input  logic [15:0] led_in,
    output logic        step_en,
    output logic        repeat_signal,
    output logic        busy,
    output logic        grant_src,
    output logic [7:0]  run_count,
    output logic        timeout_flag
);

    // state   | meaning
    // S_IDLE  | waiting for a pending request on a step tick
    // S_START | repeat_signal high for exactly one step window
    // S_RUN   | watching led_in for the all-off completion pattern
    // S_COOL  | idle steps before another grant may be issued
    typedef enum logic [1:0] {S_IDLE, S_START, S_RUN, S_COOL} state_t;

    if (PRESCALE < 2 || PRESCALE > 65535 || AUTO_PERIOD < 1 || AUTO_PERIOD > 65535 ||
        COOLDOWN < 0 || COOLDOWN > 255 || DONE_HOLD < 1 || DONE_HOLD > 15 || TIMEOUT < 1)
    begin : g_param_check
        $error("ring_flasher_sched: parameter out of range");
    end

    localparam logic [15:0] P_LAST  = 16'(PRESCALE - 1);
    // step_en is registered, so it is raised from the count one before the terminal value
    localparam logic [15:0] P_PRE   = 16'(PRESCALE - 2);
    localparam logic [15:0] A_LAST  = 16'(AUTO_PERIOD - 1);
    localparam logic [7:0]  CD_LAST = 8'((COOLDOWN == 0) ? 0 : COOLDOWN - 1);
    localparam logic [3:0]  DH_LAST = 4'(DONE_HOLD - 1);

    state_t      state;
    logic [15:0] pcnt;
    logic [15:0] atmr;
    logic        btn_pend;
    logic        auto_pend;
    logic        seen_on;
    logic [3:0]  zcnt;
    logic [7:0]  cdcnt;

    logic in_idle, grant_any, grant_btn, grant_auto, auto_expire, run_done;

    assign in_idle     = (state == S_IDLE);
    assign grant_any   = step_en && in_idle && (btn_pend || auto_pend);
    assign grant_btn   = grant_any && btn_pend;
    assign grant_auto  = grant_any && !btn_pend;
    assign auto_expire = auto_en && step_en && in_idle && !grant_any && (atmr == A_LAST);
    assign run_done    = seen_on && (led_in == 16'h0000) && (zcnt == DH_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            pcnt    <= '0;
            step_en <= 1'b0;
        end else begin
            pcnt    <= (pcnt == P_LAST) ? 16'h0000 : pcnt + 16'd1;
            step_en <= (pcnt == P_PRE);
        end
    end

    // A request arriving in the same clk as its own grant is latched again, so a held level re-arms.
    always_ff @(posedge clk) begin
        if (rst) begin
            btn_pend  <= 1'b0;
            auto_pend <= 1'b0;
            atmr      <= '0;
        end else begin
            btn_pend <= (btn_pend && !grant_btn) || btn_req;
            if (grant_auto)
                auto_pend <= 1'b0;
            else if (auto_expire)
                auto_pend <= 1'b1;
            if (!auto_en || grant_any)
                atmr <= '0;
            else if (step_en && in_idle)
                atmr <= (atmr == A_LAST) ? 16'h0000 : atmr + 16'd1;
        end
    end

`ifdef RING_FLASHER_SCHED_WATCHDOG_EN
    localparam int WD_W = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    logic [WD_W-1:0] wcnt;
    logic            wd_expire;

    assign wd_expire = (wcnt == WD_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            wcnt         <= '0;
            timeout_flag <= 1'b0;
        end else if (state == S_START) begin
            wcnt <= '0;
        end else if (state == S_RUN && step_en) begin
            wcnt <= wcnt + WD_W'(1);
            if (!run_done && wd_expire)
                timeout_flag <= 1'b1;
        end
    end
`else
    assign timeout_flag = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_IDLE;
            repeat_signal <= 1'b0;
            busy          <= 1'b0;
            grant_src     <= 1'b0;
            run_count     <= '0;
            seen_on       <= 1'b0;
            zcnt          <= '0;
            cdcnt         <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (grant_any) begin
                        state         <= S_START;
                        repeat_signal <= 1'b1;
                        busy          <= 1'b1;
                        grant_src     <= grant_auto;
                    end
                end
                S_START: begin
                    if (step_en) begin
                        state         <= S_RUN;
                        repeat_signal <= 1'b0;
                        seen_on       <= 1'b0;
                        zcnt          <= '0;
                    end
                end
                S_RUN: begin
                    if (step_en) begin
                        if (led_in != 16'h0000) begin
                            seen_on <= 1'b1;
                            zcnt    <= '0;
                        end else if (seen_on) begin
                            zcnt <= zcnt + 4'd1;
                        end
                        if (run_done) begin
                            run_count <= run_count + 8'd1;
                            seen_on   <= 1'b0;
                            zcnt      <= '0;
                            cdcnt     <= '0;
                            state     <= S_COOL;
                        end
`ifdef RING_FLASHER_SCHED_WATCHDOG_EN
                        else if (wd_expire) begin
                            seen_on <= 1'b0;
                            zcnt    <= '0;
                            cdcnt   <= '0;
                            state   <= S_COOL;
                        end
`endif
                    end
                end
                S_COOL: begin
                    if (step_en) begin
                        if (cdcnt == CD_LAST) begin
                            state <= S_IDLE;
                            busy  <= 1'b0;
                        end else begin
                            cdcnt <= cdcnt + 8'd1;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ring_flasher_sched.sv
// Self-checking bench for ring_flasher_sched: a timeline reference model plus a simple flasher stand-in.
// Watchdog scenario runs only when RING_FLASHER_SCHED_WATCHDOG_EN is defined.

module tb_ring_flasher_sched;

    localparam int P   = 4;
    localparam int AP  = 6;
    localparam int CD  = 8;
    localparam int DH  = 3;
    localparam int TO  = 16;
    localparam int CDM = (CD == 0) ? 1 : CD;
    localparam int BIG = 1 << 30;

    logic        clk = 1'b0;
    logic        rst, btn_req, auto_en;
    logic [15:0] led_in;
    logic        step_en, repeat_signal, busy, grant_src, timeout_flag;
    logic [7:0]  run_count;

    always #5 clk = ~clk;

    ring_flasher_sched #(
        .PRESCALE(P), .AUTO_PERIOD(AP), .COOLDOWN(CD), .DONE_HOLD(DH), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .rst(rst), .btn_req(btn_req), .auto_en(auto_en), .led_in(led_in),
        .step_en(step_en), .repeat_signal(repeat_signal), .busy(busy), .grant_src(grant_src),
        .run_count(run_count), .timeout_flag(timeout_flag)
    );

    int compared = 0;
    int mismatched = 0;

    // Reference model: times are clk indices since reset; a run is described by its grant
    // cycle and the first cycle at which a new grant may happen again.
    int n, grant_n, free_n, atmr, zeros, rsteps, e_cnt;
    bit bp, ap, running, seen;
    logic e_step, e_rep, e_busy, e_src, e_to;

    int fl_left;
    bit fl_lit, force_on;

    task automatic model_step(input logic r, input logic b, input logic a, input logic [15:0] l);
        bit tick, idle;
        if (r) begin
            n = 0; grant_n = -BIG; free_n = 0; atmr = 0; zeros = 0; rsteps = 0; e_cnt = 0;
            bp = 0; ap = 0; running = 0; seen = 0; e_src = 0; e_to = 0;
        end else begin
            tick = (n % P) == P - 1;
            idle = !running && n >= free_n;
            if (tick && running && n >= grant_n + 2 * P) begin
                rsteps++;
                if (l != 16'h0) begin
                    seen = 1; zeros = 0;
                end else if (seen) begin
                    zeros++;
                end
                if (seen && zeros == DH) begin
                    e_cnt = (e_cnt + 1) % 256; running = 0; free_n = n + P * CDM + 1;
                end
`ifdef RING_FLASHER_SCHED_WATCHDOG_EN
                else if (rsteps == TO) begin
                    e_to = 1; running = 0; free_n = n + P * CDM + 1;
                end
`endif
            end
            if (tick && idle && (bp || ap)) begin
                e_src = !bp;
                if (bp) bp = 0; else ap = 0;
                grant_n = n; running = 1; free_n = BIG; seen = 0; zeros = 0; rsteps = 0; atmr = 0;
            end else if (tick && idle && a) begin
                atmr++;
                if (atmr == AP) begin ap = 1; atmr = 0; end
            end
            if (!a) atmr = 0;
            if (b) bp = 1;
            n++;
        end
        e_step = (n % P) == P - 1;
        e_rep  = (n > grant_n) && (n <= grant_n + P);
        e_busy = running || (n < free_n);
    endtask

    // One clk: DUT and model sample at posedge; flasher stand-in and checks act at negedge.
    task automatic cycle();
        logic se_s, rs_s;
        se_s = step_en;
        rs_s = repeat_signal;
        @(posedge clk);
        model_step(rst, btn_req, auto_en, led_in);
        @(negedge clk);
        if (rst) begin
            fl_left = 0; led_in = 16'h0;
        end else if (se_s === 1'b1) begin
            if (rs_s === 1'b1) begin
                fl_left = $urandom_range(1, 5); fl_lit = 0;
            end else if (fl_left > 0) begin
                fl_left--;
            end
            if (force_on) led_in = 16'h0001;
            else if (fl_left > 0) begin
                if (fl_lit && $urandom_range(0, 3) == 0) led_in = 16'h0;
                else begin led_in = 16'($urandom_range(1, 65535)); fl_lit = 1; end
            end else led_in = 16'h0;
        end
    endtask

    task automatic wait_idle();
        int i = 0;
        while (!(!running && n >= free_n && !bp && !ap) && i < 1000) begin cycle(); i++; end
        compared++;
        if (i >= 1000) begin mismatched++; $display("FAIL wait_idle timeout after %0d clks", i); end
    endtask

    task automatic test_reset();
        rst = 1; btn_req = 1; auto_en = 1; led_in = 0; force_on = 0;
        cycle(); cycle();
        rst = 0; btn_req = 0; auto_en = 0;
        compared += 6;
        if (step_en !== 1'b0)       begin mismatched++; $display("FAIL reset step_en got %b want 0", step_en); end
        if (repeat_signal !== 1'b0) begin mismatched++; $display("FAIL reset repeat_signal got %b want 0", repeat_signal); end
        if (busy !== 1'b0)          begin mismatched++; $display("FAIL reset busy got %b want 0", busy); end
        if (grant_src !== 1'b0)     begin mismatched++; $display("FAIL reset grant_src got %b want 0", grant_src); end
        if (run_count !== 8'd0)     begin mismatched++; $display("FAIL reset run_count got %0d want 0", run_count); end
        if (timeout_flag !== 1'b0)  begin mismatched++; $display("FAIL reset timeout_flag got %b want 0", timeout_flag); end
        for (int i = 0; i < 20; i++) begin
            cycle();
            compared += 2;
            if (repeat_signal !== 1'b0) begin mismatched++; $display("FAIL reset_idle repeat_signal got %b want 0", repeat_signal); end
            if (busy !== 1'b0)          begin mismatched++; $display("FAIL reset_idle busy got %b want 0", busy); end
        end
    endtask

    task automatic test_prescaler();
        int pulses = 0, first = -1;
        rst = 1; cycle(); rst = 0;
        for (int i = 0; i < 40; i++) begin
            cycle();
            if (step_en === 1'b1) begin pulses++; if (first < 0) first = n; end
            compared++;
            if (step_en !== e_step) begin mismatched++; $display("FAIL prescaler step_en got %b want %b at clk %0d", step_en, e_step, n); end
        end
        compared += 2;
        if (pulses != 10)  begin mismatched++; $display("FAIL prescaler pulse_count got %0d want 10", pulses); end
        if (first != P - 1) begin mismatched++; $display("FAIL prescaler first_pulse got clk %0d want clk %0d", first, P - 1); end
    endtask

    task automatic test_button_start();
        int rep_clks = 0, rep_steps = 0, cool_busy = 0, i = 0, c0;
        bit done_seen = 0, finished = 0;
        logic prev_rep = 1'b0;
        wait_idle();
        c0 = e_cnt;
        btn_req = 1; cycle(); btn_req = 0;
        while (!finished && i < 600) begin
            cycle(); i++;
            compared += 4;
            if (repeat_signal !== e_rep) begin mismatched++; $display("FAIL btn_start repeat_signal got %b want %b at clk %0d", repeat_signal, e_rep, n); end
            if (busy !== e_busy)         begin mismatched++; $display("FAIL btn_start busy got %b want %b at clk %0d", busy, e_busy, n); end
            if (grant_src !== e_src)     begin mismatched++; $display("FAIL btn_start grant_src got %b want %b at clk %0d", grant_src, e_src, n); end
            if (run_count !== 8'(e_cnt)) begin mismatched++; $display("FAIL btn_start run_count got %0d want %0d at clk %0d", run_count, e_cnt, n); end
            if (repeat_signal === 1'b1) begin
                rep_clks++;
                if (step_en === 1'b1) rep_steps++;
                if (prev_rep !== 1'b1) begin
                    compared++;
                    if (grant_src !== 1'b0) begin mismatched++; $display("FAIL btn_start grant_src_at_rise got %b want 0", grant_src); end
                end
            end
            prev_rep = repeat_signal;
            if (run_count === 8'(c0 + 1)) done_seen = 1;
            if (done_seen && busy === 1'b1) cool_busy++;
            if (done_seen && busy === 1'b0) finished = 1;
        end
        compared += 4;
        if (!finished)          begin mismatched++; $display("FAIL btn_start timeout got no completion within %0d clks", i); end
        if (rep_clks != P)      begin mismatched++; $display("FAIL btn_start repeat_width got %0d clks want %0d", rep_clks, P); end
        if (rep_steps != 1)     begin mismatched++; $display("FAIL btn_start repeat_steps got %0d want 1", rep_steps); end
        if (cool_busy != P * CD) begin mismatched++; $display("FAIL btn_start cooldown_clks got %0d want %0d", cool_busy, P * CD); end
    endtask

    task automatic test_arbitration();
        int i = 0, rises = 0, c0;
        logic srcs [2];
        logic prev_rep = 1'b0;
        wait_idle();
        c0 = e_cnt;
        auto_en = 1;
        while (!ap && i < 300) begin cycle(); i++; end
        compared++;
        if (!ap) begin mismatched++; $display("FAIL arb auto_expiry_timeout got none within %0d clks", i); end
        btn_req = 1; cycle(); btn_req = 0; auto_en = 0;
        i = 0;
        while (!(e_cnt == (c0 + 2) % 256 && !e_busy) && i < 1200) begin
            cycle(); i++;
            compared += 3;
            if (repeat_signal !== e_rep) begin mismatched++; $display("FAIL arb repeat_signal got %b want %b at clk %0d", repeat_signal, e_rep, n); end
            if (busy !== e_busy)         begin mismatched++; $display("FAIL arb busy got %b want %b at clk %0d", busy, e_busy, n); end
            if (grant_src !== e_src)     begin mismatched++; $display("FAIL arb grant_src got %b want %b at clk %0d", grant_src, e_src, n); end
            if (repeat_signal === 1'b1 && prev_rep !== 1'b1) begin
                if (rises < 2) srcs[rises] = grant_src;
                rises++;
            end
            prev_rep = repeat_signal;
        end
        compared++;
        if (rises != 2) begin mismatched++; $display("FAIL arb grant_count got %0d want 2", rises); end
        else begin
            compared += 2;
            if (srcs[0] !== 1'b0) begin mismatched++; $display("FAIL arb first_src got %b want 0", srcs[0]); end
            if (srcs[1] !== 1'b1) begin mismatched++; $display("FAIL arb second_src got %b want 1", srcs[1]); end
        end
    endtask

    task automatic test_request_during_run();
        int i = 0, rises = 0, c0;
        logic prev_rep = 1'b0;
        wait_idle();
        c0 = e_cnt;
        btn_req = 1; cycle(); btn_req = 0;
        prev_rep = repeat_signal;
        if (repeat_signal === 1'b1) rises++;
        while (!(running && n >= grant_n + 3 * P) && i < 200) begin
            cycle(); i++;
            if (repeat_signal === 1'b1 && prev_rep !== 1'b1) rises++;
            prev_rep = repeat_signal;
        end
        btn_req = 1; cycle(); btn_req = 0;
        i = 0;
        while (!(e_cnt == (c0 + 2) % 256 && !e_busy) && i < 1200) begin
            cycle(); i++;
            compared += 3;
            if (repeat_signal !== e_rep) begin mismatched++; $display("FAIL mid_req repeat_signal got %b want %b at clk %0d", repeat_signal, e_rep, n); end
            if (busy !== e_busy)         begin mismatched++; $display("FAIL mid_req busy got %b want %b at clk %0d", busy, e_busy, n); end
            if (run_count !== 8'(e_cnt)) begin mismatched++; $display("FAIL mid_req run_count got %0d want %0d at clk %0d", run_count, e_cnt, n); end
            if (repeat_signal === 1'b1 && prev_rep !== 1'b1) rises++;
            prev_rep = repeat_signal;
        end
        compared++;
        if (rises != 2) begin mismatched++; $display("FAIL mid_req grant_count got %0d want 2", rises); end
    endtask

    task automatic test_reset_mid_run();
        int i = 0;
        wait_idle();
        btn_req = 1; cycle(); btn_req = 0;
        while (!(running && n >= grant_n + 3 * P) && i < 200) begin cycle(); i++; end
        btn_req = 1; cycle(); btn_req = 0;
        rst = 1; cycle(); rst = 0;
        compared += 5;
        if (step_en !== 1'b0)       begin mismatched++; $display("FAIL rst_mid step_en got %b want 0", step_en); end
        if (repeat_signal !== 1'b0) begin mismatched++; $display("FAIL rst_mid repeat_signal got %b want 0", repeat_signal); end
        if (busy !== 1'b0)          begin mismatched++; $display("FAIL rst_mid busy got %b want 0", busy); end
        if (grant_src !== 1'b0)     begin mismatched++; $display("FAIL rst_mid grant_src got %b want 0", grant_src); end
        if (run_count !== 8'd0)     begin mismatched++; $display("FAIL rst_mid run_count got %0d want 0", run_count); end
        for (int k = 0; k < 12 * P; k++) begin
            cycle();
            compared += 2;
            if (repeat_signal !== 1'b0) begin mismatched++; $display("FAIL rst_mid spurious repeat_signal got %b want 0 at clk %0d", repeat_signal, n); end
            if (busy !== 1'b0)          begin mismatched++; $display("FAIL rst_mid spurious busy got %b want 0 at clk %0d", busy, n); end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            btn_req = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 99) == 0) auto_en = !auto_en;
            cycle();
            compared += 6;
            if (step_en !== e_step)       begin mismatched++; $display("FAIL random step_en got %b want %b at clk %0d", step_en, e_step, n); end
            if (repeat_signal !== e_rep)  begin mismatched++; $display("FAIL random repeat_signal got %b want %b at clk %0d", repeat_signal, e_rep, n); end
            if (busy !== e_busy)          begin mismatched++; $display("FAIL random busy got %b want %b at clk %0d", busy, e_busy, n); end
            if (grant_src !== e_src)      begin mismatched++; $display("FAIL random grant_src got %b want %b at clk %0d", grant_src, e_src, n); end
            if (run_count !== 8'(e_cnt))  begin mismatched++; $display("FAIL random run_count got %0d want %0d at clk %0d", run_count, e_cnt, n); end
            if (timeout_flag !== e_to)    begin mismatched++; $display("FAIL random timeout_flag got %b want %b at clk %0d", timeout_flag, e_to, n); end
        end
        btn_req = 0; auto_en = 0;
    endtask

`ifdef RING_FLASHER_SCHED_WATCHDOG_EN
    task automatic test_watchdog();
        int i = 0;
        logic [7:0] c0;
        rst = 1; cycle(); rst = 0;
        c0 = 8'(e_cnt);
        force_on = 1;
        btn_req = 1; cycle(); btn_req = 0;
        while (!e_to && i < 600) begin
            cycle(); i++;
            compared += 3;
            if (timeout_flag !== e_to) begin mismatched++; $display("FAIL watchdog timeout_flag got %b want %b at clk %0d", timeout_flag, e_to, n); end
            if (busy !== e_busy)       begin mismatched++; $display("FAIL watchdog busy got %b want %b at clk %0d", busy, e_busy, n); end
            if (run_count !== c0)      begin mismatched++; $display("FAIL watchdog run_count got %0d want %0d", run_count, c0); end
        end
        compared += 3;
        if (timeout_flag !== 1'b1) begin mismatched++; $display("FAIL watchdog flag_set got %b want 1", timeout_flag); end
        if (busy !== 1'b1)         begin mismatched++; $display("FAIL watchdog cooldown_busy got %b want 1", busy); end
        if (run_count !== c0)      begin mismatched++; $display("FAIL watchdog count_kept got %0d want %0d", run_count, c0); end
        force_on = 0;
        wait_idle();
        compared++;
        if (timeout_flag !== 1'b1) begin mismatched++; $display("FAIL watchdog sticky got %b want 1", timeout_flag); end
    endtask
`endif

    initial begin
        test_reset();
        test_prescaler();
        test_button_start();
        test_arbitration();
        test_request_during_run();
        test_reset_mid_run();
        test_random();
`ifdef RING_FLASHER_SCHED_WATCHDOG_EN
        test_watchdog();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
